operand_feeder: RTL and testbench
=================================

Name: operand_feeder

Overview:
- Upstream stage of the MAC pipeline.
- Fetches operand pairs (A[i], B[i]) from two synchronous-read scratchpads and holds them in a 2-entry skid buffer.
- Presents each pair to the multiplier stage with can_mult.
- The pipe controller pops a pair by asserting ld_mult. The feeder produces can_mult and consumes ld_mult.

Parameters:
- DATA_W, 8, operand width.
- ADDR_W, 6, scratchpad address width. The maximum vector length is 2^ADDR_W - 1.

Ports:
- clk  in  1  system clock. All flops update on the rising edge.
- rst  in  1  asynchronous reset, active-low. Asserts immediately; deasserts synchronously to clk.
- start  in  1  single-cycle pulse that begins a job. Ignored unless the state is IDLE.
- vec_len  in  ADDR_W  number of pairs in the job. Sampled on start.
- base_a  in  ADDR_W  start address in scratchpad A. Sampled on start.
- base_b  in  ADDR_W  start address in scratchpad B. Sampled on start.
- rd_en  out  1  read strobe, shared by both scratchpads.
- addr_a  out  ADDR_W  scratchpad A read address.
- addr_b  out  ADDR_W  scratchpad B read address.
- rdata_a  in  DATA_W  A read data, valid the cycle after rd_en.
- rdata_b  in  DATA_W  B read data, valid the cycle after rd_en.
- ld_mult  in  1  pop strobe from the pipe controller.
- can_mult  out  1  head pair is valid.
- a_out  out  DATA_W  head pair, A operand.
- b_out  out  DATA_W  head pair, B operand.
- last_out  out  1  head pair is the final pair of the job.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse after the final pop.

Behaviour:
- Reset values:
  - state = IDLE.
  - All outputs 0.
  - Buffer empty.
  - issue count, pop count and in-flight flag all 0.
  - Reset mid-job discards buffered and in-flight data. No done pulse is generated.
- States:
  - IDLE: start moves to FETCH, latching vec_len, base_a and base_b. If vec_len = 0, start moves to DONE instead and no read is issued.
  - FETCH: issues reads. Moves to DRAIN on the cycle the last read is issued.
  - DRAIN: no reads. Moves to DONE on the cycle of the pop with last_out = 1.
  - DONE: done = 1 for exactly one cycle, then returns to IDLE. start arriving in DONE is ignored.
- Issue rule:
  - In FETCH, rd_en = 1 when occupancy + inflight < 2, where occupancy is 0..2 and inflight is 0 or 1.
  - The pop of the same cycle counts toward this check: if ld_mult && can_mult, occupancy is reduced by 1 first.
  - With continuous popping this gives one read per cycle.
- Addressing:
  - addr_a = base_a + issue count; addr_b = base_b + issue count.
  - Address arithmetic is modulo 2^ADDR_W; wrap is legal.
  - issue count increments on each rd_en.
- Read latency:
  - A read returns 1 cycle after rd_en.
  - The returned data is written into the buffer tail that same cycle, unconditionally.
  - Overflow is impossible by the issue rule. The bench asserts it never occurs.
- Output timing:
  - can_mult = occupancy != 0. It is driven from registered state with no combinational path from ld_mult, because the controller derives ld_mult from can_mult.
  - a_out, b_out and last_out show the head entry.
  - last_out is tagged at write time: the entry's issue index = vec_len - 1.
- Pop: ld_mult && can_mult removes the head. ld_mult while can_mult = 0 is ignored.
- Simultaneous events: a pop and a return in the same cycle both take effect; occupancy is unchanged.
- Minimum latency: start at cycle 0 gives rd_en at 1, can_mult at 2 and first pop at 2. For N pairs with no stall, the last pop is at cycle N+1 and done at N+2.

Decomposition:
- Shared pipeline package holds:
  - DATA_W and ADDR_W defaults.
  - The state encoding (IDLE, FETCH, DRAIN, DONE), 2 bits.
  - The buffer entry layout: {last, a, b}.
- One sub-module, skid_buf2:
  - Two-entry FIFO with a 1-bit pointer each for read and write, plus a 2-bit count.
  - Ports: push, pop, din, dout, count.
  - Reused later by the accumulator stage.

Test Plan:
- Basic job:
  - Stimulus: vec_len = 4, base_a = 0, base_b = 8, ld_mult held 1. A[i] = i+1, B[i] = 2i.
  - Required response: pairs (1,0), (2,2), (3,4), (4,6) on cycles 2-5; last_out only with (4,6); done at cycle 6.
- Backpressure:
  - Stimulus: vec_len = 3, ld_mult = 0 for cycles 2-6.
  - Required response: exactly 2 reads issued, can_mult = 1, head stays (1,0); the third read is issued only after the first pop.
- Zero length:
  - Stimulus: vec_len = 0.
  - Required response: no rd_en, can_mult stays 0, done at cycle 1 (IDLE to DONE), busy high for 1 cycle.
- Address wrap:
  - Stimulus: ADDR_W = 6, base_a = 62, vec_len = 4.
  - Required response: addr_a sequence 62, 63, 0, 1.
- Reset mid-job:
  - Stimulus: rst low during DRAIN with 2 entries buffered.
  - Required response: can_mult, busy and rd_en are 0 immediately, no done; a new start runs a clean job.
- Ignored inputs:
  - Stimulus: start during FETCH, and ld_mult pulses while can_mult = 0.
  - Required response: job unaffected, and no pair is lost or duplicated.

Source files
------------

// File: rtl/operand_feeder_pkg.sv
// ---------------------------------------------------------------------------
// operand_feeder_pkg
//   Shared definitions for the MAC pipeline front end:
//   - default operand / address widths
//   - operand feeder state encoding (2 bits)
//   - buffer entry layout {last, a, b}
// ---------------------------------------------------------------------------
package operand_feeder_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Entry layout at the default width; parameterised users pack the
    // same field order {last, a, b} into a flat vector of entry_w() bits.
    typedef struct packed {
        logic                  last;
        logic [DATA_W_DEF-1:0] a;
        logic [DATA_W_DEF-1:0] b;
    } entry_t;

    function automatic int entry_w(input int data_w);
        return 2 * data_w + 1;
    endfunction

endpackage

// File: rtl/operand_feeder_skid_buf2.sv
// ---------------------------------------------------------------------------
// skid_buf2
//   Two-entry FIFO with 1-bit read/write pointers and a 2-bit count.
//   Ports:
//     clk, rst  clock, asynchronous active-low reset
//     push      write din at the tail (unconditional; caller guarantees room)
//     pop       remove head entry (ignored when empty)
//     din       entry to write
//     dout      head entry (registered storage, no path from pop)
//     count     number of valid entries, 0..2
// ---------------------------------------------------------------------------
module skid_buf2 #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_pop;

    assign do_pop = pop && (count != 2'd0);
    assign dout   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            // A push and a pop in the same cycle leave the count unchanged.
            case ({push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/operand_feeder.sv
// ---------------------------------------------------------------------------
// operand_feeder
//   Fetches operand pairs (A[i], B[i]) from two synchronous-read scratchpads
//   and presents them to the multiplier stage through a 2-entry skid buffer.
//   Ports:
//     clk, rst                 clock, asynchronous active-low reset
//     start, vec_len,
//     base_a, base_b           job launch (sampled in IDLE only)
//     rd_en, addr_a, addr_b    shared read strobe and addresses
//     rdata_a, rdata_b         read data, valid the cycle after rd_en
//     ld_mult                  pop strobe from the pipe controller
//     can_mult                 head pair valid
//     a_out, b_out, last_out   head pair and its end-of-job tag
//     busy                     state is not IDLE
//     done                     one-cycle pulse after the final pop
//     state_dbg                current FSM state
//
//   Handshake: a pair transfers on every cycle where can_mult && ld_mult are
//   both high at the rising edge. can_mult depends only on registered state,
//   so the controller may build ld_mult combinationally from it; ld_mult while
//   can_mult is low has no effect.
// ---------------------------------------------------------------------------
module operand_feeder
    import operand_feeder_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] vec_len,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] rdata_a,
    input  logic [DATA_W-1:0] rdata_b,
    input  logic              ld_mult,
    output logic              can_mult,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              last_out,
    output logic              busy,
    output logic              done,
    output state_t            state_dbg
);

    localparam int EW = entry_w(DATA_W);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] base_a_q;
    logic [ADDR_W-1:0] base_b_q;
    logic [ADDR_W-1:0] issue_cnt;
    logic              inflight;
    logic              inflight_last;
    logic [1:0]        occ;
    logic [1:0]        occ_eff;
    logic              pop;
    logic              last_issue;
    logic [EW-1:0]     head;

    assign can_mult   = (occ != 2'd0);
    assign pop        = ld_mult && can_mult;
    // The pop of this cycle frees a slot before the issue check.
    assign occ_eff    = occ - {1'b0, pop};
    assign last_issue = (issue_cnt == len_q - 1'b1);

    assign addr_a    = base_a_q + issue_cnt;
    assign addr_b    = base_b_q + issue_cnt;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign state_dbg = state;

    assign last_out = head[EW-1];
    assign a_out    = head[2*DATA_W-1:DATA_W];
    assign b_out    = head[DATA_W-1:0];

    always_comb begin
        state_nx = state;
        rd_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = (vec_len == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Buffered + in-flight must stay within the two buffer slots.
                if ({1'b0, occ_eff} + {2'b00, inflight} < 3'd2) begin
                    rd_en = 1'b1;
                    if (last_issue) begin
                        state_nx = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && last_out) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            len_q         <= '0;
            base_a_q      <= '0;
            base_b_q      <= '0;
            issue_cnt     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && start) begin
                len_q     <= vec_len;
                base_a_q  <= base_a;
                base_b_q  <= base_b;
                issue_cnt <= '0;
            end else if (rd_en) begin
                issue_cnt <= issue_cnt + 1'b1;
            end
            // The tag travels with the read so the entry knows it is last.
            inflight      <= rd_en;
            inflight_last <= rd_en && last_issue;
        end
    end

    skid_buf2 #(
        .W(EW)
    ) u_buf (
        .clk  (clk),
        .rst  (rst),
        .push (inflight),
        .pop  (pop),
        .din  ({inflight_last, rdata_a, rdata_b}),
        .dout (head),
        .count(occ)
    );

endmodule

// File: tb/tb_operand_feeder.sv
module tb_operand_feeder;
    import operand_feeder_pkg::*;

    localparam int DW = 8;
    localparam int AW = 6;
    localparam int EW = 2 * DW + 1;
    localparam int DEPTH = 1 << AW;

    // ---------------- clock / reset ----------------
    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] vec_len;
    logic [AW-1:0] base_a;
    logic [AW-1:0] base_b;
    logic          rd_en;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] rdata_a;
    logic [DW-1:0] rdata_b;
    logic          ld_mult;
    logic          can_mult;
    logic [DW-1:0] a_out;
    logic [DW-1:0] b_out;
    logic          last_out;
    logic          busy;
    logic          done;
    state_t        state_dbg;

    int cyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    operand_feeder #(
        .DATA_W(DW),
        .ADDR_W(AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .vec_len  (vec_len),
        .base_a   (base_a),
        .base_b   (base_b),
        .rd_en    (rd_en),
        .addr_a   (addr_a),
        .addr_b   (addr_b),
        .rdata_a  (rdata_a),
        .rdata_b  (rdata_b),
        .ld_mult  (ld_mult),
        .can_mult (can_mult),
        .a_out    (a_out),
        .b_out    (b_out),
        .last_out (last_out),
        .busy     (busy),
        .done     (done),
        .state_dbg(state_dbg)
    );

    // ---------------- scratchpad models ----------------
    logic [DW-1:0] mem_a [DEPTH];
    logic [DW-1:0] mem_b [DEPTH];

    initial begin
        rdata_a = '0;
        rdata_b = '0;
    end

    always @(posedge clk) begin
        if (rd_en) begin
            rdata_a <= mem_a[addr_a];
            rdata_b <= mem_b[addr_b];
        end
    end

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    logic [AW-1:0] exp_addr_a_q[$];
    logic [AW-1:0] exp_addr_b_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int done_due = -1;
    int issued = 0;
    int popped = 0;
    int job_reads = 0;
    int ld_mode = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flush_model();
        exp_q.delete();
        exp_addr_a_q.delete();
        exp_addr_b_q.delete();
        done_due = -1;
        issued   = 0;
        popped   = 0;
    endtask

    // Monitor: samples mid-cycle, pops expectations on each transfer/read.
    always @(negedge clk) begin
        if (rst) begin
            if (done_due == cyc) begin
                check("done_pulse", 32'(done), 32'd1);
                done_due = -1;
            end else if (done) begin
                check("done_spurious", 32'(done), 32'd0);
            end

            if (rd_en) begin
                issued++;
                job_reads++;
                if (exp_addr_a_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rd_en_extra: got read at addr_a %0d, expected no read (cycle %0d)",
                             addr_a, cyc);
                end else begin
                    check("addr_a", 32'(addr_a), 32'(exp_addr_a_q.pop_front()));
                    check("addr_b", 32'(addr_b), 32'(exp_addr_b_q.pop_front()));
                end
            end

            if (ld_mult && can_mult) begin
                logic [EW-1:0] e;
                popped++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL pop_extra: got pair %0h, expected no pair (cycle %0d)",
                             {last_out, a_out, b_out}, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("pair", 32'({last_out, a_out, b_out}), 32'(e));
                    if (e[EW-1]) done_due = cyc + 1;
                end
            end

            // Reads outstanding (buffered + in flight) never exceed two slots.
            if (rd_en) check("slot_bound", 32'(issued - popped <= 2), 32'd1);
        end
    end

    // ---------------- driver tasks ----------------
    initial begin
        ld_mult = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ld_mode)
                0:       ld_mult = 1'b1;
                1:       ld_mult = 1'($urandom_range(0, 1));
                default: ld_mult = 1'b0;
            endcase
        end
    end

    task automatic fill_basic();
        for (int j = 0; j < DEPTH; j++) begin
            mem_a[j] = DW'(j + 1);
            mem_b[j] = DW'(2 * (j - 8));
        end
    endtask

    task automatic fill_random();
        for (int j = 0; j < DEPTH; j++) begin
            mem_a[j] = DW'($urandom_range(0, 255));
            mem_b[j] = DW'($urandom_range(0, 255));
        end
    endtask

    // Reference: job of len pairs reads A[base_a+i], B[base_b+i] modulo depth.
    task automatic start_job(input int len, input int ba, input int bb, output int sc);
        @(posedge clk);
        #1;
        vec_len   = AW'(len);
        base_a    = AW'(ba);
        base_b    = AW'(bb);
        start     = 1'b1;
        sc        = cyc;
        job_reads = 0;
        for (int i = 0; i < len; i++) begin
            logic [AW-1:0] aa;
            logic [AW-1:0] ab;
            aa = AW'(ba + i);
            ab = AW'(bb + i);
            exp_addr_a_q.push_back(aa);
            exp_addr_b_q.push_back(ab);
            exp_q.push_back({(i == len - 1), mem_a[aa], mem_b[ab]});
        end
        if (len == 0) done_due = sc + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        flush_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic wait_job_end(input int bound);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy || done_due != -1) && k < bound) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= bound) begin
            n_cmp++;
            n_err++;
            $display("FAIL job_timeout: got %0d pairs still pending after %0d cycles, expected 0",
                     exp_q.size(), bound);
            @(posedge clk);
            #1;
            do_reset();
        end
    endtask

    // Hard stop in case something upstream of the bounded waits hangs.
    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence ----------------
    initial begin
        int sc;
        rst     = 1'b0;
        start   = 1'b0;
        vec_len = '0;
        base_a  = '0;
        base_b  = '0;
        fill_basic();

        #12;
        check("rst_can_mult", 32'(can_mult), 32'd0);
        check("rst_outputs", 32'({a_out, b_out, last_out}), 32'd0);
        check("rst_busy_done", 32'({busy, done}), 32'd0);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_addr", 32'({addr_a, addr_b}), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Basic job, continuous popping.
        ld_mode = 0;
        start_job(4, 0, 8, sc);
        check("basic_first_read", 32'({rd_en, addr_a, addr_b}), 32'({1'b1, 6'd0, 6'd8}));
        wait_job_end(40);
        check("basic_reads", 32'(job_reads), 32'd4);

        // Backpressure: nothing popped, only two reads may be outstanding.
        ld_mode = 2;
        start_job(3, 0, 8, sc);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("bp_reads", 32'(job_reads), 32'd2);
        check("bp_can_mult", 32'(can_mult), 32'd1);
        check("bp_head", 32'({last_out, a_out, b_out}), 32'({1'b0, 8'd1, 8'd0}));
        check("bp_no_read", 32'(rd_en), 32'd0);
        ld_mode = 0;
        wait_job_end(40);
        check("bp_total_reads", 32'(job_reads), 32'd3);

        // Zero-length job.
        start_job(0, 5, 5, sc);
        check("zero_busy", 32'(busy), 32'd1);
        check("zero_can_mult", 32'({can_mult, rd_en}), 32'd0);
        @(posedge clk);
        #1;
        check("zero_busy_end", 32'(busy), 32'd0);
        check("zero_reads", 32'(job_reads), 32'd0);
        wait_job_end(10);

        // Address wrap.
        fill_random();
        start_job(4, 62, 3, sc);
        wait_job_end(40);

        // Reset during DRAIN with two entries buffered.
        ld_mode = 2;
        start_job(2, 10, 20, sc);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("mid_state", 32'(state_dbg), 32'(ST_DRAIN));
        check("mid_can_mult", 32'(can_mult), 32'd1);
        rst = 1'b0;
        flush_model();
        #1;
        check("mid_rst_outputs", 32'({can_mult, busy, rd_en, done}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        ld_mode = 0;
        start_job(5, 30, 40, sc);
        wait_job_end(40);
        check("post_rst_reads", 32'(job_reads), 32'd5);

        // start during FETCH is ignored; random ld_mult pulses while empty.
        ld_mode = 1;
        fill_random();
        start_job(6, 7, 50, sc);
        check("stray_state", 32'(state_dbg), 32'(ST_FETCH));
        vec_len = AW'(2);
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_job_end(100);
        check("stray_reads", 32'(job_reads), 32'd6);

        // Randomised jobs.
        for (int j = 0; j < 10; j++) begin
            int len;
            fill_random();
            ld_mode = int'($urandom_range(0, 1));
            len = (j == 3) ? DEPTH - 1 : int'($urandom_range(1, 20));
            start_job(len, int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)), sc);
            wait_job_end(len * 8 + 40);
            check("rand_reads", 32'(job_reads), 32'(len));
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
